// File: rtl/mock_array_pkg.sv
// Shared widths and the result record used by the mock-array edge adapter.
package mock_array_pkg;
  localparam int WORD_W = 64;
  localparam int RES_W  = 16;

  typedef struct packed {
    logic             err;
    logic [RES_W-1:0] data;
  } res_t;

  localparam int RES_T_W = $bits(res_t);

  // Width of an occupancy counter that must be able to hold the value 'depth'.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/element_edge_adapter_if.sv
// Word stream in, Element edge pair, and result stream out of the edge adapter.
interface element_edge_adapter_if;
  import mock_array_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [WORD_W-1:0] edge_out;
  logic [WORD_W-1:0] edge_in;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              res_err;
  logic              err_seen;

  modport slave (
    input  in_valid, in_data, edge_in, res_ready,
    output in_ready, edge_out, res_valid, res_data, res_err, err_seen
  );

  modport master (
    output in_valid, in_data, edge_in, res_ready,
    input  in_ready, edge_out, res_valid, res_data, res_err, err_seen
  );
endinterface

// File: rtl/edge_fifo.sv
// Show-ahead synchronous FIFO; data_o is the head entry whenever empty_o is low.
module edge_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // Storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/element_edge_adapter.sv
// Drives buffered words onto one Element edge and collects the response LATENCY
// cycles later, issuing only while result storage has room for every word in flight.
module element_edge_adapter
  import mock_array_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int RES_DEPTH = 4,
  parameter int LATENCY   = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  element_edge_adapter_if.slave  bus
);
  localparam int IN_CW  = cntWidth(DEPTH);
  localparam int RES_CW = cntWidth(RES_DEPTH);

  logic [WORD_W-1:0]  inHead;
  logic               inFull, inEmpty, inPush;
  logic [IN_CW-1:0]   inCount;
  logic [RES_T_W-1:0] resHeadBits;
  res_t               resHead, captured;
  logic               resFull, resEmpty, resPop;
  logic [RES_CW-1:0]  resCount;
  logic               issue, capture;

  logic [WORD_W-1:0]  edgeOut_q, edgeOut_d;
  logic [LATENCY:0]   tag_q, tag_d;
  logic [RES_CW-1:0]  inflight_q, inflight_d;
  logic               errSeen_q, errSeen_d;

  assign inPush       = bus.in_valid && !inFull;
  assign bus.in_ready = !inFull;

  edge_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) inFifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (inPush),
    .data_i  (bus.in_data),
    .pop_i   (issue),
    .data_o  (inHead),
    .full_o  (inFull),
    .empty_o (inEmpty),
    .count_o (inCount)
  );

  assign capture  = tag_q[LATENCY];
  assign captured = '{err: |bus.edge_in[WORD_W-1:RES_W], data: bus.edge_in[RES_W-1:0]};

  edge_fifo #(.WIDTH(RES_T_W), .DEPTH(RES_DEPTH)) resFifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (capture),
    .data_i  (captured),
    .pop_i   (resPop),
    .data_o  (resHeadBits),
    .full_o  (resFull),
    .empty_o (resEmpty),
    .count_o (resCount)
  );

  assign resHead       = res_t'(resHeadBits);
  assign bus.res_valid = !resEmpty;
  assign bus.res_data  = resEmpty ? '0 : resHead.data;
  assign bus.res_err   = resEmpty ? 1'b0 : resHead.err;
  assign resPop        = !resEmpty && bus.res_ready;
  assign bus.edge_out  = edgeOut_q;
  assign bus.err_seen  = errSeen_q;

  // A result popped this cycle still holds its credit, so the window never overcommits.
  assign issue = !inEmpty &&
                 (({1'b0, resCount} + {1'b0, inflight_q}) < (RES_CW + 1)'(RES_DEPTH));

  always_comb begin
    edgeOut_d  = issue ? inHead : '0;
    tag_d      = {tag_q[LATENCY-1:0], issue};
    inflight_d = inflight_q;
    case ({issue, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    errSeen_d  = errSeen_q | (capture & captured.err);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edgeOut_q  <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
      errSeen_q  <= 1'b0;
    end else begin
      edgeOut_q  <= edgeOut_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      errSeen_q  <= errSeen_d;
    end
  end

  resultNoOverflow: assert property (@(posedge clock) disable iff (!reset_n)
                                     capture |-> !resFull);
  inputCountBound:  assert property (@(posedge clock) disable iff (!reset_n)
                                     inCount <= IN_CW'(DEPTH));
endmodule
